// File: rtl/vector_register_file_ldq.sv
// Vector register file: two combinational read ports, one lane-masked vector write
// port and an element-serial load port. Define VRF_WRITE_BYPASS_EN for same-cycle read forwarding.
module vector_register_file_ldq #(
  parameter int WIDTH        = 16,
  parameter int VECTOR_SIZE  = 16,
  parameter int NUM_VECTORES = 16,
  localparam int AW = $clog2(NUM_VECTORES),
  localparam int LW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [AW-1:0]          v1,
  input  logic [AW-1:0]          v2,
  output logic [WIDTH-1:0]       vd1 [VECTOR_SIZE],
  output logic [WIDTH-1:0]       vd2 [VECTOR_SIZE],
  input  logic                   we3,
  input  logic [AW-1:0]          v3,
  input  logic [WIDTH-1:0]       wd3 [VECTOR_SIZE],
  input  logic [VECTOR_SIZE-1:0] wmask3,
  input  logic                   ld_start,
  input  logic [AW-1:0]          ld_vreg,
  input  logic                   ld_valid,
  input  logic [WIDTH-1:0]       ld_data,
  output logic                   ld_ready,
  output logic                   ld_busy,
  output logic                   ld_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [LW-1:0]     cnt_r;
  logic [AW-1:0]     dst_r;
  logic              beat_s;
  logic              last_s;
  logic [WIDTH-1:0]  mem [NUM_VECTORES][VECTOR_SIZE];

  // Beat qualification: ready is only ever high in LOAD
  always_comb begin
    beat_s = (state_r == S_LOAD) && ld_valid;
    last_s = beat_s && (cnt_r == LW'(VECTOR_SIZE - 1));
  end

  // Next-state logic of the serial-load sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ld_start) state_s = S_LOAD;
        else          state_s = S_IDLE;
      end
      S_LOAD: begin
        if (last_s) state_s = S_DONE;
        else        state_s = S_LOAD;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Status outputs decode the state register; forced low while reset is applied
  always_comb begin
    ld_ready = 1'b0;
    ld_busy  = 1'b0;
    ld_done  = 1'b0;
    if (rst) begin
      ld_ready = 1'b0;
      ld_busy  = 1'b0;
      ld_done  = 1'b0;
    end else begin
      ld_ready = (state_r == S_LOAD);
      ld_busy  = (state_r == S_LOAD);
      ld_done  = (state_r == S_DONE);
    end
  end

  // Sequencer state, destination register and element counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      dst_r   <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == S_IDLE && ld_start) begin
        dst_r <= ld_vreg;
        cnt_r <= '0;
      end else if (beat_s) begin
        cnt_r <= cnt_r + LW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Register storage; a load beat overrides the vector write on the same lane
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_VECTORES; r++)
        for (int i = 0; i < VECTOR_SIZE; i++)
          mem[r][i] <= '0;
    end else begin
      for (int r = 1; r < NUM_VECTORES; r++)
        for (int i = 0; i < VECTOR_SIZE; i++)
          if (beat_s && dst_r == AW'(r) && cnt_r == LW'(i))
            mem[r][i] <= ld_data;
          else if (we3 && v3 == AW'(r) && wmask3[i])
            mem[r][i] <= wd3[i];
          else
            mem[r][i] <= mem[r][i];
    end
  end

  function automatic logic [WIDTH-1:0] read_lane(input logic [AW-1:0] addr, input int lane);
    logic [WIDTH-1:0] val;
    if (rst || addr == '0)
      val = '0;
`ifdef VRF_WRITE_BYPASS_EN
    else if (beat_s && addr == dst_r && cnt_r == LW'(lane))
      val = ld_data;
    else if (we3 && addr == v3 && wmask3[lane])
      val = wd3[lane];
`endif
    else
      val = mem[addr][lane];
    return val;
  endfunction

  // Combinational read ports
  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) begin
      vd1[i] = read_lane(v1, i);
      vd2[i] = read_lane(v2, i);
    end
  end

endmodule

// File: tb/tb_vector_register_file_ldq.sv
// Directed self-checking bench for vector_register_file_ldq: table-driven masked
// write/read vectors plus hand-written serial-load, collision, reset and bypass sequences.
module tb_vector_register_file_ldq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v1, v2, v3, ld_vreg;
  logic [15:0] vd1 [16];
  logic [15:0] vd2 [16];
  logic [15:0] wd3 [16];
  logic        we3;
  logic [15:0] wmask3;
  logic        ld_start, ld_valid, ld_ready, ld_busy, ld_done;
  logic [15:0] ld_data;

  int checks = 0;
  int errors = 0;

  vector_register_file_ldq #(.WIDTH(16), .VECTOR_SIZE(16), .NUM_VECTORES(16)) dut (
    .clk(clk), .rst(rst), .v1(v1), .v2(v2), .vd1(vd1), .vd2(vd2),
    .we3(we3), .v3(v3), .wd3(wd3), .wmask3(wmask3),
    .ld_start(ld_start), .ld_vreg(ld_vreg), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  wa;
    logic [15:0] wbase;
    logic [15:0] wmask;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [15:0] m1;
    logic [15:0] b1;
    logic [15:0] m2;
    logic [15:0] b2;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // lane i expected = mask[i] ? base+i : lo
  task automatic chkv(input string name, input int port, input logic [15:0] mask,
                      input logic [15:0] base, input logic [15:0] lo);
    int bad = -1;
    logic [15:0] a, e, ab, eb;
    ab = '0;
    eb = '0;
    for (int i = 0; i < 16; i++) begin
      a = (port == 1) ? vd1[i] : vd2[i];
      e = mask[i] ? base + 16'(i) : lo;
      if (a !== e && bad < 0) begin
        bad = i;
        ab  = a;
        eb  = e;
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: port %0d lane %0d got %h expected %h", name, port, bad, ab, eb);
    end
  endtask

  task automatic set_wd(input logic [15:0] base);
    for (int i = 0; i < 16; i++) wd3[i] = base + 16'(i);
  endtask

  task automatic set_wd_all(input logic [15:0] val);
    for (int i = 0; i < 16; i++) wd3[i] = val;
  endtask

  task automatic beat(input logic [15:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    #1;
    chk1("ld_ready_beat", ld_ready, 1'b1);
    chk1("ld_done_in_load", ld_done, 1'b0);
    step();
    ld_valid = 1'b0;
  endtask

  task automatic start_load(input logic [3:0] r);
    ld_start = 1'b1;
    ld_vreg  = r;
    step();
    ld_start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'd3,  16'h0100, 16'h00FF, 4'd3,  4'd5,  16'h00FF, 16'h0100, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 4'd0,  16'h5555, 16'hFFFF, 4'd0,  4'd3,  16'h0000, 16'h0000, 16'h00FF, 16'h0100};
    tbl[2] = '{1'b1, 4'd3,  16'h0100, 16'hFF00, 4'd3,  4'd0,  16'hFFFF, 16'h0100, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 4'd15, 16'h7F00, 16'h8001, 4'd15, 4'd3,  16'h8001, 16'h7F00, 16'hFFFF, 16'h0100};
    tbl[4] = '{1'b0, 4'd15, 16'h1111, 16'hFFFF, 4'd15, 4'd14, 16'h8001, 16'h7F00, 16'h0000, 16'h0000};
    tbl[5] = '{1'b1, 4'd14, 16'hBEEF, 16'hAAAA, 4'd14, 4'd15, 16'hAAAA, 16'hBEEF, 16'h8001, 16'h7F00};

    rst = 1'b1; we3 = 1'b0; v1 = 4'd5; v2 = 4'd15; v3 = 4'd0; wmask3 = 16'h0000;
    ld_start = 1'b0; ld_vreg = 4'd0; ld_valid = 1'b0; ld_data = 16'h0000;
    set_wd(16'h0000);

    // reset
    step();
    chk1("ready_in_rst", ld_ready, 1'b0);
    chkv("vd1_in_rst", 1, 16'h0000, 16'h0000, 16'h0000);
    rst = 1'b0;
    step();
    chkv("vd1_after_rst", 1, 16'h0000, 16'h0000, 16'h0000);
    chkv("vd2_after_rst", 2, 16'h0000, 16'h0000, 16'h0000);
    chk1("ready_after_rst", ld_ready, 1'b0);
    chk1("busy_after_rst", ld_busy, 1'b0);
    chk1("done_after_rst", ld_done, 1'b0);

    // masked write / read table
    for (int t = 0; t < 6; t++) begin
      we3 = tbl[t].we; v3 = tbl[t].wa; wmask3 = tbl[t].wmask; set_wd(tbl[t].wbase);
      step();
      we3 = 1'b0; v1 = tbl[t].ra1; v2 = tbl[t].ra2;
      #1;
      chkv($sformatf("tbl%0d_vd1", t), 1, tbl[t].m1, tbl[t].b1, 16'h0000);
      chkv($sformatf("tbl%0d_vd2", t), 2, tbl[t].m2, tbl[t].b2, 16'h0000);
      step();
    end

    // serial load with a 3-cycle stall after beat 5
    ld_start = 1'b1; ld_vreg = 4'd7;
    #1;
    chk1("busy_idle", ld_busy, 1'b0);
    chk1("ready_idle", ld_ready, 1'b0);
    step();
    ld_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin
        for (int s = 0; s < 3; s++) begin
          ld_valid = 1'b0;
          #1;
          chk1("ready_stall", ld_ready, 1'b1);
          chk1("done_stall", ld_done, 1'b0);
          step();
        end
      end
      beat(16'hA000 + 16'(k));
    end
    ld_start = 1'b1; ld_vreg = 4'd3;
    #1;
    chk1("done_pulse", ld_done, 1'b1);
    chk1("ready_in_done", ld_ready, 1'b0);
    step();
    ld_start = 1'b0;
    v1 = 4'd7;
    #1;
    chk1("done_single", ld_done, 1'b0);
    chk1("start_in_done_ignored", ld_busy, 1'b0);
    chkv("load_data", 1, 16'hFFFF, 16'hA000, 16'h0000);

    // collision: vector write and load beat on reg 7 lane 4
    step();
    start_load(4'd7);
    for (int k = 0; k < 4; k++) beat(16'hC000 + 16'(k));
    we3 = 1'b1; v3 = 4'd7; wmask3 = 16'hFFFF; set_wd_all(16'hFFFF);
    beat(16'hC004);
    we3 = 1'b0; v1 = 4'd7;
    #1;
    chkv("collision", 1, 16'h0010, 16'hC000, 16'hFFFF);
    step();
    for (int k = 5; k < 16; k++) beat(16'hC000 + 16'(k));
    #1;
    chk1("done_collision", ld_done, 1'b1);
    step();
    #1;
    chkv("collision_end", 1, 16'hFFF0, 16'hC000, 16'hFFFF);

    // reset mid-load, then immediate restart to reg 9
    step();
    start_load(4'd7);
    for (int k = 0; k < 9; k++) beat(16'hD000 + 16'(k));
    rst = 1'b1;
    #1;
    chk1("busy_in_rst_mid", ld_busy, 1'b0);
    chk1("ready_in_rst_mid", ld_ready, 1'b0);
    step();
    rst = 1'b0; ld_start = 1'b1; ld_vreg = 4'd9; v1 = 4'd7; v2 = 4'd3;
    #1;
    chk1("busy_after_rst_mid", ld_busy, 1'b0);
    chkv("rst_clear_v7", 1, 16'h0000, 16'h0000, 16'h0000);
    chkv("rst_clear_v3", 2, 16'h0000, 16'h0000, 16'h0000);
    step();
    ld_start = 1'b0;
    #1;
    chk1("restart_accepted", ld_busy, 1'b1);
    for (int k = 0; k < 16; k++) beat(16'hE000 + 16'(k));
    #1;
    chk1("done_latency", ld_done, 1'b1);
    step();
    v1 = 4'd9;
    #1;
    chkv("load_v9", 1, 16'hFFFF, 16'hE000, 16'h0000);

    // load to reg 0 is handshaked but stores nothing
    step();
    start_load(4'd0);
    for (int k = 0; k < 16; k++) beat(16'hF000 + 16'(k));
    #1;
    chk1("done_reg0", ld_done, 1'b1);
    step();
    v1 = 4'd0; v2 = 4'd9;
    #1;
    chkv("reg0_zero", 1, 16'h0000, 16'h0000, 16'h0000);
    chkv("v9_untouched", 2, 16'hFFFF, 16'hE000, 16'h0000);

    // same-cycle write and read of reg 2
    step();
    we3 = 1'b1; v3 = 4'd2; wmask3 = 16'hFFFF; set_wd_all(16'h1234); v1 = 4'd2;
    #1;
`ifdef VRF_WRITE_BYPASS_EN
    chkv("bypass_same_cycle", 1, 16'h0000, 16'h0000, 16'h1234);
`else
    chkv("bypass_same_cycle", 1, 16'h0000, 16'h0000, 16'h0000);
`endif
    step();
    we3 = 1'b0;
    #1;
    chkv("bypass_next_cycle", 1, 16'h0000, 16'h0000, 16'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_register_file_ldq.md
Name: vector_register_file_ldq

Overview:
- Parametrised next-generation vector register file for the vector datapath (decode/execute boundary).
- Two combinational read ports and one full-vector write port with per-lane write mask; register 0 is hardwired to zero.
- Adds an element-serial load port: a valid/ready-handshaked stream from memory fills one vector register one element per beat, under a small FSM.
- Data port width and lane count are parameters; no lane count is hardcoded.

Parameters:
- WIDTH, 16, bits per element.
- VECTOR_SIZE, 16, elements (lanes) per vector register.
- NUM_VECTORES, 16, number of vector registers; minimum 2.
- Local: AW = $clog2(NUM_VECTORES); LW = $clog2(VECTOR_SIZE), minimum 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- v1  in  AW  read address, port 1.
- v2  in  AW  read address, port 2.
- vd1  out  WIDTH x VECTOR_SIZE  read data, port 1 (unpacked array of lanes).
- vd2  out  WIDTH x VECTOR_SIZE  read data, port 2.
- we3  in  1  vector write enable.
- v3  in  AW  vector write address.
- wd3  in  WIDTH x VECTOR_SIZE  vector write data.
- wmask3  in  VECTOR_SIZE  per-lane write mask; bit i=1 writes lane i.
- ld_start  in  1  start serial load; sampled only in IDLE.
- ld_vreg  in  AW  destination register for serial load; captured on accepted ld_start.
- ld_valid  in  1  element beat valid.
- ld_data  in  WIDTH  element beat data.
- ld_ready  out  1  element beat accepted when ld_valid && ld_ready.
- ld_busy  out  1  high while in LOAD.
- ld_done  out  1  one-cycle pulse after the last element is written.

Behaviour:
- Reads are combinational: vdN[i] = 0 when vN==0, else vector[vN][i].
- Vector write: on posedge with we3=1 and v3!=0, lane i is updated with wd3[i] only when wmask3[i]=1. Lanes with mask 0 hold their value. Writes to register 0 are ignored.
- Serial-load FSM states: IDLE, LOAD, DONE.
  - IDLE: ld_ready=0, ld_busy=0. On ld_start=1: capture ld_vreg into dst, clear element counter cnt to 0, go to LOAD.
  - LOAD: ld_ready=1, ld_busy=1. On each beat, vector[dst][cnt] <= ld_data and cnt increments. The beat with cnt==VECTOR_SIZE-1 goes to DONE. Stalls (ld_valid=0) are held indefinitely with no timeout.
  - DONE: ld_done=1 for exactly one cycle, ld_ready=0, then IDLE. Back-to-back: an ld_start asserted in DONE is ignored; the earliest accepted start is the cycle after ld_done.
  - ld_start while in LOAD/DONE is ignored. When dst==0, beats are still handshaked and counted, but no storage is written; ld_done still pulses.
- Load latency: ld_start (cycle 0) -> LOAD from cycle 1 -> with no stalls, ld_done in cycle VECTOR_SIZE+1.
- Simultaneous writes: if the vector write and a load beat target the same register and lane in the same cycle, the load beat wins for that lane. Other masked lanes take wd3.
- Reset (rst=1 at posedge): all registers cleared to 0, FSM to IDLE, cnt=0, dst=0. Reset mid-load aborts the load; partially written lanes are also cleared. Output values during and after reset: ld_ready=0, ld_busy=0, ld_done=0, vd1/vd2=0.

Optional Feature:
- Macro: VRF_WRITE_BYPASS_EN.
- Defined: read ports forward same-cycle write data per lane. If vN==v3!=0 && we3 && wmask3[i], then vdN[i]=wd3[i]. If vN==dst!=0 and a beat is accepted at lane cnt, vdN[cnt]=ld_data. Load forwarding has priority over vector-write forwarding.
- Not defined: reads return stored contents only; new data is visible the cycle after the write edge.

Test Plan:
- Reset then read: rst=1 one cycle; v1=5, v2=15 -> vd1, vd2 all lanes 0; ld_ready=0, ld_done=0.
- Masked write: we3=1, v3=3, wd3[i]=16'h0100+i, wmask3=16'h00FF; next cycle v1=3 -> lanes 0-7 = 0x0100-0x0107, lanes 8-15 = 0. Write to v3=0 -> v1=0 still reads 0.
- Serial load with stalls: ld_start, ld_vreg=7; 16 beats ld_data=0xA000+k, ld_valid dropped for 3 cycles after beat 5 -> ld_done single pulse exactly one cycle after beat 15; v1=7 reads 0xA000-0xA00F.
- Collision: during a load to reg 7 at cnt=4, we3=1, v3=7, wmask3=all ones, wd3=0xFFFF -> lane 4 = ld_data, all other lanes = 0xFFFF.
- Reset mid-load: rst after beat 8 -> FSM IDLE, ld_busy=0, reg 7 all zero; a new ld_start is accepted the cycle after reset deasserts.
- Bypass: with VRF_WRITE_BYPASS_EN, we3=1, v3=2, wd3=0x1234 and v1=2 in the same cycle -> vd1=0x1234 in that cycle. Without the macro -> vd1 shows the old value, then 0x1234 the next cycle.
